// File: rtl/tta_pm_loader_if.sv
// Program-memory bus and loader byte stream between the TTA core side and tta_pm_loader.
// master = core plus byte source; slave = the loader/RAM responder.
interface tta_pm_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] pm_address;
    logic [15:0] pm_data_out;
    logic [15:0] pm_data_in;
    logic        pm_write;

    modport master (
        output rx_data, rx_valid, pm_address, pm_data_in, pm_write,
        input  rx_ready, pm_data_out
    );

    modport slave (
        input  rx_data, rx_valid, pm_address, pm_data_in, pm_write,
        output rx_ready, pm_data_out
    );
endinterface

// File: rtl/tta_pm_loader.sv
// TTA program-memory responder with a big-endian byte-stream boot loader.
// Optional trailing XOR checksum byte: define TTA_PM_LOADER_CHECKSUM_EN.
module tta_pm_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_start,
    tta_pm_loader_if.slave     bus,
    output logic               cpu_hold,
    output logic               load_busy,
    output logic               load_done,
    output logic               load_error
);
    localparam int          DEPTH_WORDS = 1 << ADDR_WIDTH;
    localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH_WORDS);

`ifdef TTA_PM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR} state_t;
    localparam state_t AFTER_LOAD = CHECK;
`else
    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, DONE, ERROR} state_t;
    localparam state_t AFTER_LOAD = DONE;
`endif

    state_t                  state, state_next;
    logic [7:0]              byte_latch;
    logic [15:0]             remaining;
    logic [ADDR_WIDTH-1:0]   addr;
`ifdef TTA_PM_LOADER_CHECKSUM_EN
    logic [7:0]              checksum;
`endif

    logic [15:0]             mem [0:DEPTH_WORDS-1];
    logic                    accept;
    logic [15:0]             count_word;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [15:0]             mem_wdata;
    logic [ADDR_WIDTH-1:0]   core_addr;
    logic                    unused_addr_bits;

    // Upper address bits alias onto the RAM.
    assign core_addr        = bus.pm_address[ADDR_WIDTH-1:0];
    assign unused_addr_bits = ^bus.pm_address[15:ADDR_WIDTH];
    assign bus.pm_data_out  = mem[core_addr];

    assign count_word = {byte_latch, bus.rx_data};
    // load_start wins over a byte offered on the same edge.
    assign accept     = bus.rx_valid && bus.rx_ready && !load_start;

    always_comb begin
        state_next   = state;
        bus.rx_ready = 1'b0;
        load_busy    = 1'b0;
        load_done    = 1'b0;
        load_error   = 1'b0;
        cpu_hold     = 1'b1;
        unique case (state)
            IDLE: ;
            CNT_HI: begin
                bus.rx_ready = 1'b1;
                load_busy    = 1'b1;
                if (accept) state_next = CNT_LO;
            end
            CNT_LO: begin
                bus.rx_ready = 1'b1;
                load_busy    = 1'b1;
                if (accept) begin
                    if (count_word == 16'd0)                 state_next = AFTER_LOAD;
                    else if ({1'b0, count_word} > DEPTH_LIMIT) state_next = ERROR;
                    else                                     state_next = DATA_HI;
                end
            end
            DATA_HI: begin
                bus.rx_ready = 1'b1;
                load_busy    = 1'b1;
                if (accept) state_next = DATA_LO;
            end
            DATA_LO: begin
                bus.rx_ready = 1'b1;
                load_busy    = 1'b1;
                if (accept) state_next = (remaining == 16'd1) ? AFTER_LOAD : DATA_HI;
            end
`ifdef TTA_PM_LOADER_CHECKSUM_EN
            CHECK: begin
                bus.rx_ready = 1'b1;
                load_busy    = 1'b1;
                if (accept) state_next = (bus.rx_data == checksum) ? DONE : ERROR;
            end
`endif
            DONE: begin
                load_done = 1'b1;
                cpu_hold  = 1'b0;
            end
            ERROR: load_error = 1'b1;
            default: state_next = IDLE;
        endcase
        if (load_start) state_next = CNT_HI;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_latch <= 8'd0;
            remaining  <= 16'd0;
            addr       <= '0;
`ifdef TTA_PM_LOADER_CHECKSUM_EN
            checksum   <= 8'd0;
`endif
        end else if (load_start) begin
            byte_latch <= 8'd0;
            remaining  <= 16'd0;
            addr       <= '0;
`ifdef TTA_PM_LOADER_CHECKSUM_EN
            checksum   <= 8'd0;
`endif
        end else if (accept) begin
`ifdef TTA_PM_LOADER_CHECKSUM_EN
            checksum <= checksum ^ bus.rx_data;
`endif
            case (state)
                CNT_HI:  byte_latch <= bus.rx_data;
                CNT_LO: begin
                    remaining <= count_word;
                    addr      <= '0;
                end
                DATA_HI: byte_latch <= bus.rx_data;
                DATA_LO: begin
                    addr      <= addr + ADDR_WIDTH'(1);
                    remaining <= remaining - 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Loader writes only in DATA_LO, core writes only in DONE, so one port suffices.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr;
        mem_wdata = {byte_latch, bus.rx_data};
        if (state == DATA_LO && accept) begin
            mem_we = 1'b1;
        end else if (state == DONE && bus.pm_write) begin
            mem_we    = 1'b1;
            mem_addr  = core_addr;
            mem_wdata = bus.pm_data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
endmodule
